// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: owns the 5-stage pipeline enables/flushes, serialising
// multi-cycle memory accesses, load-use bubbles and taken-branch flushes.
module pipeline_stall_controller #(
    parameter int             OPW     = 4,
    parameter logic [OPW-1:0] STR_OP  = 4'b1010,
    parameter logic [OPW-1:0] LDR_OP  = 4'b1100,
    parameter logic [OPW-1:0] B_OP    = 4'b1111,
    parameter logic [OPW-1:0] BEQ_OP  = 4'b1101,
    parameter logic [OPW-1:0] BLT_OP  = 4'b1110,
    parameter int             TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [3:0]     ex_rd,
    input  logic [3:0]     id_rs1,
    input  logic [3:0]     id_rs2,
    input  logic           id_use_rs1,
    input  logic           id_use_rs2,
    input  logic           flagN,
    input  logic           flagZ,
    input  logic           mem_ready,
    input  logic           cnt_clr,
    output logic           pc_en,
    output logic           if_id_en,
    output logic           id_ex_en,
    output logic           ex_mem_en,
    output logic           flush_if_id,
    output logic           flush_id_ex,
    output logic           pc_src,
    output logic           mem_req,
    output logic           mem_err,
    output logic           busy,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    flush_cnt
);
    typedef enum logic {IDLE, MEM_WAIT} state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic        mem_op, load_use, br_taken;
    logic        pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
    logic        flush_if_id_c, flush_id_ex_c, pc_src_c, mem_req_c;

    always_comb begin
        mem_op   = ex_valid & (ex_opcode == STR_OP | ex_opcode == LDR_OP);
        load_use = ex_valid & ex_opcode == LDR_OP &
                   ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd));
        br_taken = ex_valid & (ex_opcode == B_OP | (ex_opcode == BEQ_OP & flagZ) |
                               (ex_opcode == BLT_OP & flagN));
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        pc_src_c      = 1'b0;
        mem_req_c     = 1'b0;
        if (state_q == IDLE) begin
            mem_req_c = mem_op;
            if (mem_op & ~mem_ready) begin
                {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c} = 4'b0000;
                state_d    = MEM_WAIT;
                wait_cnt_d = 16'd1;
            end else if (br_taken) begin
                pc_src_c      = 1'b1;
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
            end else if (load_use) begin
                pc_en_c       = 1'b0;
                if_id_en_c    = 1'b0;
                flush_id_ex_c = 1'b1;
            end
        end else begin
            mem_req_c  = 1'b1;
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (mem_ready) begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == TO) begin
                // Abort: retire the access as if it completed and flag the error.
                mem_err_d  = 1'b1;
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else begin
                {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c} = 4'b0000;
            end
        end
        stall_cnt_d = cnt_clr ? '0 :
                      (~pc_en_c & stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = cnt_clr ? '0 :
                      (flush_if_id_c & flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Combinational controls are held inactive for as long as reset is asserted.
    assign pc_en       = rst_n & pc_en_c;
    assign if_id_en    = rst_n & if_id_en_c;
    assign id_ex_en    = rst_n & id_ex_en_c;
    assign ex_mem_en   = rst_n & ex_mem_en_c;
    assign flush_if_id = rst_n & flush_if_id_c;
    assign flush_id_ex = rst_n & flush_id_ex_c;
    assign pc_src      = rst_n & pc_src_c;
    assign mem_req     = rst_n & mem_req_c;
    assign busy        = rst_n & (state_q == MEM_WAIT);
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed checks of stalls, bubbles, flushes, timeout and counters.
module tb_pipeline_stall_controller;
    localparam logic [3:0] STR = 4'b1010, LDR = 4'b1100, B = 4'b1111, BEQ = 4'b1101, BLT = 4'b1110;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_valid, id_use_rs1, id_use_rs2, flagN, flagZ, mem_ready, cnt_clr;
    logic [3:0] ex_opcode, ex_rd, id_rs1, id_rs2;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex, pc_src, mem_req, mem_err, busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, flush_if_id2, flush_id_ex2, pc_src2, mem_req2, mem_err2, busy2;
    logic [15:0] stall_cnt2, flush_cnt2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .flagN(flagN), .flagZ(flagZ), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_src(pc_src), .mem_req(mem_req),
        .mem_err(mem_err), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_stall_controller #(.TIMEOUT(65535)) dut_long (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .flagN(flagN), .flagZ(flagZ), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_en(pc_en2), .if_id_en(if_id_en2), .id_ex_en(id_ex_en2), .ex_mem_en(ex_mem_en2),
        .flush_if_id(flush_if_id2), .flush_id_ex(flush_id_ex2), .pc_src(pc_src2), .mem_req(mem_req2),
        .mem_err(mem_err2), .busy(busy2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(negedge clk);
    endtask

    task automatic chk_en(input string tag, input logic [3:0] exp);
        chk(tag, {12'd0, pc_en, if_id_en, id_ex_en, ex_mem_en}, {12'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b1; ex_opcode = STR; ex_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; flagN = 1'b0; flagZ = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
        nx; nx; #1;
        chk("rst_mem_req", mem_req, 0);
        chk_en("rst_en", 4'b0000);
        chk("rst_flush", {flush_if_id, flush_id_ex, pc_src}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_mem_err", mem_err, 0);
        // STR, ready on the third busy cycle
        nx; rst_n = 1'b1; #1;
        chk("str_req_idle", mem_req, 1);
        chk_en("str_en_idle", 4'b0000);
        chk("str_busy_idle", busy, 0);
        nx; #1;
        chk("str_busy1", busy, 1);
        chk("str_pc_en1", pc_en, 0);
        chk("str_cnt1", stall_cnt, 1);
        nx; #1;
        chk("str_busy2", busy, 1);
        chk("str_pc_en2", pc_en, 0);
        nx; mem_ready = 1'b1; #1;
        chk("str_busy3", busy, 1);
        chk_en("str_ready_en", 4'b1111);
        chk("str_ready_req", mem_req, 1);
        chk("str_cnt3", stall_cnt, 3);
        nx; ex_valid = 1'b0; mem_ready = 1'b0; #1;
        chk("str_done_busy", busy, 0);
        chk("str_done_cnt", stall_cnt, 3);
        chk_en("str_done_en", 4'b1111);
        // load-use via rs2
        nx; ex_valid = 1'b1; ex_opcode = LDR; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1; mem_ready = 1'b1; #1;
        chk_en("lu_en", 4'b0011);
        chk("lu_flush", {flush_if_id, flush_id_ex}, 16'b01);
        chk("lu_req", mem_req, 1);
        nx; ex_valid = 1'b0; #1;
        chk_en("lu_after_en", 4'b1111);
        chk("lu_after_flush", flush_id_ex, 0);
        chk("lu_cnt", stall_cnt, 4);
        nx; ex_valid = 1'b1; id_use_rs2 = 1'b0; #1;
        chk_en("lu_nouse_en", 4'b1111);
        chk("lu_nouse_flush", flush_id_ex, 0);
        nx; id_rs1 = 4'd5; id_use_rs1 = 1'b1; #1;
        chk_en("lu_rs1_en", 4'b0011);
        nx; id_rs1 = 4'd6; #1;
        chk_en("lu_rs1_miss_en", 4'b1111);
        chk("lu_rs1_cnt", stall_cnt, 5);
        // branches
        nx; ex_opcode = BEQ; mem_ready = 1'b0; flagZ = 1'b1; #1;
        chk("beq_t_src", pc_src, 1);
        chk("beq_t_flush", {flush_if_id, flush_id_ex}, 16'b11);
        chk("beq_t_pc_en", pc_en, 1);
        chk("beq_t_req", mem_req, 0);
        nx; flagZ = 1'b0; #1;
        chk("beq_nt_src", pc_src, 0);
        chk("beq_nt_flush", {flush_if_id, flush_id_ex}, 0);
        chk("beq_flush_cnt", flush_cnt, 1);
        nx; ex_opcode = BLT; flagN = 1'b1; #1;
        chk("blt_t_flush", {flush_if_id, flush_id_ex}, 16'b11);
        nx; ex_opcode = B; ex_valid = 1'b0; #1;
        chk("b_invalid_src", pc_src, 0);
        chk("b_invalid_cnt", flush_cnt, 2);
        nx; ex_valid = 1'b1; flagN = 1'b0; #1;
        chk("b_src", pc_src, 1);
        nx; ex_valid = 1'b0; #1;
        chk("br_flush_cnt", flush_cnt, 3);
        chk("br_stall_cnt", stall_cnt, 5);
        chk("pre_to_err", mem_err, 0);
        // timeout with TIMEOUT=4
        nx; ex_valid = 1'b1; ex_opcode = LDR; id_use_rs1 = 1'b0; #1;
        chk("to_pc_en0", pc_en, 0);
        for (int i = 1; i <= 3; i++) begin
            nx; #1;
            chk("to_wait_pc_en", pc_en, 0);
            chk("to_wait_busy", busy, 1);
        end
        nx; #1;
        chk_en("to_retire_en", 4'b1111);
        chk("to_retire_busy", busy, 1);
        chk("to_retire_cnt", stall_cnt, 9);
        nx; ex_valid = 1'b0; #1;
        chk("to_err", mem_err, 1);
        chk("to_idle", busy, 0);
        chk("to_cnt_hold", stall_cnt, 9);
        nx; ex_valid = 1'b1; ex_opcode = STR; mem_ready = 1'b1; #1;
        chk("to_err_sticky", mem_err, 1);
        // saturation on the long-timeout instance
        nx; mem_ready = 1'b0;
        for (int i = 0; i < 66000; i++) nx;
        #1;
        chk("sat_cnt", stall_cnt2, 16'hFFFF);
        nx; #1;
        chk("sat_hold", stall_cnt2, 16'hFFFF);
        chk("sat_busy", busy2, 1);
        nx; cnt_clr = 1'b1; #1;
        chk("clr_stalling", pc_en2, 0);
        nx; cnt_clr = 1'b0; #1;
        chk("clr_stall_cnt", stall_cnt2, 0);
        chk("clr_flush_cnt", flush_cnt, 0);
        chk("clr_err_kept", mem_err, 1);
        // asynchronous reset while waiting
        #1; rst_n = 1'b0; #1;
        chk("rst_wait_req", mem_req2, 0);
        chk("rst_wait_busy", busy2, 0);
        chk("rst_wait_err", mem_err, 0);
        chk("rst_wait_cnt", stall_cnt, 0);
        nx; ex_valid = 1'b0; nx; rst_n = 1'b1; #1;
        chk("rel_busy", busy2, 0);
        chk("rel_req", mem_req2, 0);
        chk_en("rel_en", 4'b1111);
        nx; #1;
        chk("rel_idle", busy2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
